// File: rtl/lane_deskew_pkg.sv
// Shared types and sizing helpers for the lane deskew aligner.
// Holds the FSM state enum and pointer/counter width helpers.
package lane_deskew_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } state_e;

  localparam int MAX_SKEW_DEF = 8;
  localparam int DEPTH_DEF    = MAX_SKEW_DEF + 2;
  localparam int PTR_W        = $clog2(DEPTH_DEF);
  localparam int CNT_W        = $clog2(MAX_SKEW_DEF + 2);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lane_deskew_fifo.sv
// One lane's circular buffer: shared write pointer, own read pointer.
// Ports: i_clk, i_we, i_wr_ptr, i_wdata, i_rd_ptr, o_rdata (async read).
module lane_deskew_fifo #(
  parameter int WIDTH = 1361,
  parameter int DEPTH = 10,
  parameter int PW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_wr_ptr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_rd_ptr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_wr_ptr] <= i_wdata;
  end

  // Combinational read: a same-cycle write lands after the edge,
  // so the registered output always sees the old entry.
  assign o_rdata = mem_q[i_rd_ptr];

endmodule

// File: rtl/lane_deskew_aligner.sv
// Receive lane deskew: per-lane buffers, HUNT/ALIGNED FSM, aligned output.
// Ports: i_clk, i_rst_n (sync, low), i_valid, i_data[], i_sync ->
//   o_data[], o_sync, o_valid, o_aligned, o_skew_err, o_lock_lost.
// Macro LANE_DESKEW_STATUS_EN adds o_skew_depth[] (per-lane skew).
module lane_deskew_aligner
  import lane_deskew_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int LANE_WIDTH = 1360,
  parameter int MAX_SKEW   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [LANE_WIDTH-1:0] i_data [NUM_LANES],
  input  logic [NUM_LANES-1:0]  i_sync,
  output logic [LANE_WIDTH-1:0] o_data [NUM_LANES],
  output logic [NUM_LANES-1:0]  o_sync,
  output logic                  o_valid,
  output logic                  o_aligned,
  output logic                  o_skew_err,
  output logic                  o_lock_lost
`ifdef LANE_DESKEW_STATUS_EN
  ,
  output logic [ptr_w(MAX_SKEW+2)-1:0] o_skew_depth [NUM_LANES]
`endif
);

  localparam int DEPTH = MAX_SKEW + 2;
  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = ptr_w(MAX_SKEW + 2);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] seen_q, seen_d;
  logic [NUM_LANES-1:0] newm;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_q, wr_d;
  logic [PW-1:0]        mark_q [NUM_LANES];
  logic [PW-1:0]        mark_d [NUM_LANES];
  logic [PW-1:0]        rd_q [NUM_LANES];
  logic [PW-1:0]        rd_d [NUM_LANES];
  logic [LANE_WIDTH:0]  rdata [NUM_LANES];
  logic [NUM_LANES-1:0] rsync;
  logic                 rd_en, we;
  logic                 skew_err_d, lock_lost_d;

  assign we    = i_valid & i_rst_n;
  assign rd_en = i_valid && (state_q == ALIGNED);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_deskew_fifo #(
      .WIDTH (LANE_WIDTH + 1),
      .DEPTH (DEPTH),
      .PW    (PW)
    ) u_fifo (
      .i_clk    (i_clk),
      .i_we     (we),
      .i_wr_ptr (wr_q),
      .i_wdata  ({i_sync[l], i_data[l]}),
      .i_rd_ptr (rd_q[l]),
      .o_rdata  (rdata[l])
    );
    assign rsync[l] = rdata[l][LANE_WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    mark_d      = mark_q;
    rd_d        = rd_q;
    newm        = '0;
    skew_err_d  = 1'b0;
    lock_lost_d = 1'b0;
    if (i_valid) begin
      wr_d = inc(wr_q);
      unique case (state_q)
        HUNT: begin
          // Overflow beat discards its own flags.
          if (seen_q != '0 && int'(cnt_q) + 1 > MAX_SKEW) begin
            skew_err_d = 1'b1;
            seen_d     = '0;
            cnt_d      = '0;
          end else begin
            newm   = i_sync & ~seen_q;
            seen_d = seen_q | i_sync;
            cnt_d  = (seen_q != '0) ? cnt_q + 1'b1 : '0;
            for (int l = 0; l < NUM_LANES; l++) begin
              if (newm[l]) mark_d[l] = wr_q;
            end
            if (&seen_d) begin
              state_d = ALIGNED;
              rd_d    = mark_d;
            end
          end
        end
        ALIGNED: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            rd_d[l] = inc(rd_q[l]);
          end
          if (rsync != '0 && !(&rsync)) begin
            lock_lost_d = 1'b1;
            state_d     = HUNT;
            seen_d      = '0;
            cnt_d       = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= HUNT;
      seen_q      <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      o_sync      <= '0;
      o_valid     <= 1'b0;
      o_aligned   <= 1'b0;
      o_skew_err  <= 1'b0;
      o_lock_lost <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        mark_q[l] <= '0;
        rd_q[l]   <= '0;
        o_data[l] <= '0;
      end
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      o_valid     <= rd_en;
      o_aligned   <= (state_d == ALIGNED);
      o_skew_err  <= skew_err_d;
      o_lock_lost <= lock_lost_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        mark_q[l] <= mark_d[l];
        rd_q[l]   <= rd_d[l];
      end
      if (rd_en) begin
        o_sync <= rsync;
        for (int l = 0; l < NUM_LANES; l++) begin
          o_data[l] <= rdata[l][LANE_WIDTH-1:0];
        end
      end
    end
  end

`ifdef LANE_DESKEW_STATUS_EN
  // Skew of a lane = beats between its marker and the latest marker.
  function automatic logic [PW-1:0] dist(input logic [PW-1:0] a,
                                         input logic [PW-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d += DEPTH;
    return PW'(d);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state_d == HUNT) begin
      for (int l = 0; l < NUM_LANES; l++) o_skew_depth[l] <= '0;
    end else if (state_q == HUNT) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        o_skew_depth[l] <= dist(wr_q, rd_d[l]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_deskew_aligner.sv
// Scoreboard bench for lane_deskew_aligner (4 lanes x 8 bits, skew 3).
// Beat-indexed history model predicts outputs; monitor compares.
module tb_lane_deskew_aligner;

  localparam int NL = 4;
  localparam int LW = 8;
  localparam int MS = 3;

  typedef struct packed {
    logic valid;
    logic aligned;
    logic skew;
    logic lost;
    logic zchk;
  } st_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [LW-1:0] data [NL];
  logic [NL-1:0] sync;
  logic [LW-1:0] o_data [NL];
  logic [NL-1:0] o_sync;
  logic          o_valid, o_aligned, o_skew_err, o_lock_lost;
`ifdef LANE_DESKEW_STATUS_EN
  logic [2:0]    skd [NL];
`endif

  int checks = 0;
  int failures = 0;

  st_t         st_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] hist[$];

  bit          m_al, m_hunt;
  int          m_first, m_rdn;
  logic [3:0]  m_seen;
  int          m_mark [NL];

  always #5 clk = ~clk;

  lane_deskew_aligner #(
    .NUM_LANES  (NL),
    .LANE_WIDTH (LW),
    .MAX_SKEW   (MS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_data      (data),
    .i_sync      (sync),
    .o_data      (o_data),
    .o_sync      (o_sync),
    .o_valid     (o_valid),
    .o_aligned   (o_aligned),
    .o_skew_err  (o_skew_err),
    .o_lock_lost (o_lock_lost)
`ifdef LANE_DESKEW_STATUS_EN
    ,
    .o_skew_depth (skd)
`endif
  );

  task automatic chk(input string nm, input logic [35:0] got,
                     input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: absolute beat indices into an unbounded history.
  task automatic model(input logic rst, input logic v,
                       input logic [3:0] s, input logic [31:0] d);
    st_t         st;
    logic [35:0] w, e;
    logic [3:0]  es;
    int          idx;
    st = '0;
    w  = '0;
    e  = '0;
    es = '0;
    if (!rst) begin
      m_al   = 0;
      m_hunt = 0;
      m_seen = '0;
      st.zchk = 1'b1;
    end else if (v) begin
      for (int l = 0; l < NL; l++) w[l*9 +: 9] = {s[l], d[l*8 +: 8]};
      idx = hist.size();
      hist.push_back(w);
      if (m_al) begin
        for (int l = 0; l < NL; l++) begin
          e[l*9 +: 9] = hist[m_mark[l] + m_rdn][l*9 +: 9];
          es[l] = e[l*9 + 8];
        end
        m_rdn++;
        st.valid = 1'b1;
        exp_q.push_back(e);
        if (es != 4'h0 && es != 4'hF) begin
          st.lost = 1'b1;
          m_al    = 0;
          m_seen  = '0;
          m_hunt  = 0;
        end
      end else if (m_hunt && idx - m_first > MS) begin
        st.skew = 1'b1;
        m_hunt  = 0;
        m_seen  = '0;
      end else if (s != '0) begin
        if (!m_hunt) begin
          m_hunt  = 1;
          m_first = idx;
        end
        for (int l = 0; l < NL; l++) begin
          if (s[l] && !m_seen[l]) begin
            m_seen[l] = 1'b1;
            m_mark[l] = idx;
          end
        end
        if (m_seen == 4'hF) begin
          m_al   = 1;
          m_rdn  = 0;
          m_hunt = 0;
        end
      end
    end
    st.aligned = m_al;
    st_q.push_back(st);
  endtask

  task automatic cyc(input logic rst, input logic v,
                     input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    rst_n = rst;
    valid = v;
    sync  = s;
    for (int l = 0; l < NL; l++) data[l] = d[l*8 +: 8];
    model(rst, v, s, d);
  endtask

  task automatic vb(input logic [3:0] s, input logic [31:0] d,
                    input bit gap);
    if (gap) cyc(1'b1, 1'b0, 4'($urandom), $urandom);
    cyc(1'b1, 1'b1, s, d);
  endtask

  task automatic beats(input int n, input bit gap);
    for (int i = 0; i < n; i++) vb(4'h0, $urandom, gap);
  endtask

  task automatic marker(input int o0, input int o1, input int o2,
                        input int o3, input bit gap,
                        input logic [7:0] base, input bit fix);
    int         o [NL];
    int         span;
    logic [3:0] s;
    logic [31:0] d;
    o = '{o0, o1, o2, o3};
    span = 0;
    for (int l = 0; l < NL; l++) if (o[l] > span) span = o[l];
    for (int k = 0; k <= span; k++) begin
      d = $urandom;
      s = '0;
      for (int l = 0; l < NL; l++) begin
        if (o[l] == k) begin
          s[l] = 1'b1;
          if (fix) d[l*8 +: 8] = base + 8'(l);
        end
      end
      vb(s, d, gap);
    end
  endtask

  // Monitor: one status entry per driven cycle, data on o_valid.
  initial begin
    st_t         s;
    logic [35:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      got = '0;
      for (int l = 0; l < NL; l++) got[l*9 +: 9] = {o_sync[l], o_data[l]};
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("o_valid", 36'(o_valid), 36'(s.valid));
        chk("o_aligned", 36'(o_aligned), 36'(s.aligned));
        chk("o_skew_err", 36'(o_skew_err), 36'(s.skew));
        chk("o_lock_lost", 36'(o_lock_lost), 36'(s.lost));
        if (s.zchk) chk("reset_outs", got, 36'h0);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", got, 36'hx);
        end else begin
          e = exp_q.pop_front();
          chk("aligned_data", got, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    sync  = '0;
    for (int l = 0; l < NL; l++) data[l] = '0;
    cyc(1'b0, 1'b0, 4'h0, 32'h0);
    cyc(1'b0, 1'b1, 4'hF, $urandom);
    // Zero skew lock
    beats(4, 0);
    marker(0, 0, 0, 0, 0, 8'hA0, 1);
    beats(6, 0);
    // Maximum tolerated skew
    cyc(1'b0, 1'b0, 4'h0, 32'h0);
    beats(3, 0);
    marker(0, 1, 2, 3, 0, 8'h50, 1);
    beats(8, 0);
    // Lock loss then relock
    vb(4'b0010, $urandom, 0);
    beats(5, 0);
    marker(0, 0, 0, 0, 0, 8'hC0, 1);
    beats(5, 0);
    // Overflow, late lane flag must not seed a new hunt
    cyc(1'b0, 1'b0, 4'h0, 32'h0);
    beats(2, 0);
    marker(0, 0, 0, 4, 0, 8'h20, 1);
    beats(6, 0);
    marker(0, 0, 0, 0, 0, 8'h30, 1);
    beats(4, 0);
    // Gapped valid with skew 2
    cyc(1'b0, 1'b0, 4'h0, 32'h0);
    marker(0, 2, 1, 2, 1, 8'h70, 1);
    beats(6, 1);
    // Reset mid-stream
    cyc(1'b0, 1'b1, 4'h0, $urandom);
    beats(5, 0);
    marker(1, 0, 1, 0, 0, 8'h90, 1);
    beats(4, 0);
    // Randomised traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: beats($urandom_range(1, 8), 1'($urandom));
        3, 4, 5: marker($urandom_range(0, MS + 1), $urandom_range(0, MS + 1),
                        $urandom_range(0, MS + 1), $urandom_range(0, MS),
                        1'($urandom), 8'h00, 0);
        6: marker(0, 0, 0, 0, 1'($urandom), 8'h00, 0);
        7: vb(4'(1 << $urandom_range(0, NL - 1)), $urandom, 0);
        8: vb(4'($urandom), $urandom, 1'($urandom));
        default: begin
          if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom), 4'($urandom), $urandom);
          else beats(2, 0);
        end
      endcase
    end
    repeat (3) cyc(1'b1, 1'b0, 4'h0, 32'h0);
    @(posedge clk);
    #2;
    chk("drain", 36'(exp_q.size()), 36'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_deskew_aligner.md
Name: lane_deskew_aligner

Overview:
Parametrised receive-side lane realignment buffer placed directly after lane_shuffler in the 1.6T PCS/AUI chain. Accepts NUM_LANES parallel lanes, each carrying a per-lane sync flag. Absorbs up to MAX_SKEW beats of inter-lane skew in per-lane circular buffers and emits all lanes time-aligned. Detects skew overflow and loss of alignment, then re-hunts automatically.

Parameters:
NUM_LANES, 16, number of physical lanes
LANE_WIDTH, 1360, data bits per lane per beat
MAX_SKEW, 8, maximum tolerated skew in i_valid beats between earliest and latest sync flag
DEPTH, MAX_SKEW+2, per-lane buffer entries (derived; not overridden)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  input beat qualifier; all lanes are valid together
i_data  in  [NUM_LANES][LANE_WIDTH]  unpacked lane array, same shape as the lane_shuffler output
i_sync  in  NUM_LANES  per-lane sync/marker flag for the current beat
o_data  out  [NUM_LANES][LANE_WIDTH]  aligned lane data
o_sync  out  NUM_LANES  aligned sync flags
o_valid  out  1  o_data/o_sync qualifier
o_aligned  out  1  high while in ALIGNED
o_skew_err  out  1  one-cycle pulse: skew exceeded MAX_SKEW
o_lock_lost  out  1  one-cycle pulse: partial sync seen while ALIGNED

Behaviour:
- Reset (i_rst_n low at posedge) behaves the same from any state, including mid-hunt or mid-stream. It sets state to HUNT and clears all pointers, the seen mask and the skew counter. o_data, o_sync, o_valid, o_aligned, o_skew_err and o_lock_lost all reset to 0.
- Each lane stores {sync, data} (LANE_WIDTH+1 bits) per beat. In every state except reset, a write happens on each i_valid beat. wr_ptr is shared by all lanes and wraps modulo DEPTH.
- Only i_valid beats advance pointers or counters. Cycles with i_valid low are ignored entirely.
- HUNT:
  - On an i_valid beat with any i_sync bit set, record mark_ptr[l] = wr_ptr for each flagged lane not already seen, and set seen[l].
  - skew_cnt starts at 0 on the first flagged beat and increments on each later i_valid beat.
  - A lane flagging again while already seen is ignored.
  - If seen becomes all-ones on a beat with skew_cnt <= MAX_SKEW, go to ALIGNED and set rd_ptr[l] = mark_ptr[l].
  - If skew_cnt would reach MAX_SKEW+1 without all lanes seen, pulse o_skew_err, clear seen and skew_cnt, and stay in HUNT. That beat's own flags do not seed the new hunt.
- ALIGNED:
  - On each i_valid beat, o_data[l]/o_sync[l] <= buffer[l][rd_ptr[l]], rd_ptr[l]++ modulo DEPTH, and o_valid <= 1. Otherwise o_valid <= 0.
  - Latency is one cycle from the i_valid beat to o_valid. The first o_valid beat after lock carries all-ones o_sync.
  - When a read and a write hit the same entry on the same cycle, the read returns the old contents. DEPTH = MAX_SKEW+2 guarantees the earliest lane's marker is never overwritten.
  - Lock loss: if a read beat yields o_sync that is neither all-zero nor all-ones, pulse o_lock_lost, go to HUNT and clear seen. That beat's o_valid is still asserted with the read data.
- o_aligned = (state == ALIGNED), registered.
- Simultaneous skew overflow and new flags: overflow wins.

Optional Feature:
LANE_DESKEW_STATUS_EN
- Defined: adds output o_skew_depth [NUM_LANES][$clog2(DEPTH)], holding each lane's measured skew (rd_ptr offset relative to the latest-marked lane). It is latched on lock and cleared in HUNT and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package lane_deskew_pkg holds:
  - state enum {HUNT, ALIGNED}
  - localparam helpers PTR_W = $clog2(DEPTH) and CNT_W = $clog2(MAX_SKEW+2)
- Sub-module lane_deskew_fifo: one per lane via generate, containing a DEPTH x (LANE_WIDTH+1) storage array with shared-wr_ptr write and independent rd_ptr read.
- The top level holds the FSM, seen mask, skew counter and output registers.

Test Plan (NUM_LANES=4, LANE_WIDTH=8, MAX_SKEW=3):
1. Zero skew: all i_sync on beat 5 with data 8'hA0+lane -> o_aligned=1 at the next posedge; first o_valid beat has o_sync=4'hF and o_data={A3,A2,A1,A0}.
2. Max skew: lane sync beats 10,11,12,13, each lane's marker data = 8'h5l -> lock on beat 13; next o_valid beat has o_sync=4'hF and o_data={53,52,51,50}; subsequent beats stay lane-aligned.
3. Overflow: lanes 0-2 sync on beat 20, lane 3 on beat 24 -> o_skew_err pulses exactly once on beat 24, o_aligned stays 0, and lane 3's beat-24 sync does not count toward a new hunt.
4. Lock loss: after lock, inject sync only on lane 1 -> o_sync=4'b0010 appears with o_valid=1, o_lock_lost pulses, o_aligned drops the same cycle; a later full marker relocks.
5. Gapped valid: lock with i_valid toggling 1,0,1,0 and skew 2 -> identical aligned output sequence to the gap-free case; o_valid only on cycles after i_valid beats.
6. Reset mid-stream: assert i_rst_n=0 for one cycle while ALIGNED -> every output is 0 the next cycle, state is HUNT, and no o_valid appears until a new full marker set.
